// File: rtl/apb_req_master_if.sv
// Request/response channel and APB3 port bundle for apb_req_master.
// No logic or latency; master modport is the APB master (the DUT), slave is its environment.
// Backpressure: carries req_ready_o / rsp_ready_i / pready_i as plain wires.
interface apb_req_master_if #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32
) ();
    logic                      req_valid_i;
    logic                      req_ready_o;
    logic [APB_ADDR_WIDTH-1:0] req_addr_i;
    logic                      req_write_i;
    logic [APB_DATA_WIDTH-1:0] req_wdata_i;
    logic                      rsp_valid_o;
    logic                      rsp_ready_i;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_o;
    logic                      rsp_err_o;
    logic                      psel_o;
    logic                      penable_o;
    logic                      pwrite_o;
    logic [APB_ADDR_WIDTH-1:0] paddr_o;
    logic [APB_DATA_WIDTH-1:0] pwdata_o;
    logic [APB_DATA_WIDTH-1:0] prdata_i;
    logic                      pready_i;
    logic                      pslverr_i;

    modport master (
        input  req_valid_i, req_addr_i, req_write_i, req_wdata_i, rsp_ready_i,
        input  prdata_i, pready_i, pslverr_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
    );

    modport slave (
        output req_valid_i, req_addr_i, req_write_i, req_wdata_i, rsp_ready_i,
        output prdata_i, pready_i, pslverr_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
    );
endinterface

// File: rtl/apb_req_master.sv
// Valid/ready request -> APB3 SETUP/ACCESS master, one transfer outstanding; optional watchdog via APB_REQ_TIMEOUT_EN.
// Latency: handshake cycle N -> psel N+1 -> penable N+2 -> rsp_valid N+3 with zero-wait pready.
// Backpressure: req_ready_o only in IDLE; response held in RESP until rsp_ready_i.
module apb_req_master #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    apb_req_master_if.master  bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e                    state_q, state_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      pwrite_q, pwrite_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_err_q, rsp_err_d;
`ifdef APB_REQ_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
    logic [15:0]               cnt_q, cnt_d;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_REQ_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_REQ_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Outputs are registered: each branch sets the values seen in the next state.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_REQ_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    paddr_d  = bus.req_addr_i & ~APB_ADDR_WIDTH'(3);
                    pwrite_d = bus.req_write_i;
                    pwdata_d = bus.req_wdata_i;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
`ifdef APB_REQ_TIMEOUT_EN
                cnt_d     = '0;
`endif
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (bus.pready_i) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_err_d   = bus.pslverr_i;
                    rsp_rdata_d = (pwrite_q || bus.pslverr_i) ? '0 : bus.prdata_i;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
`ifdef APB_REQ_TIMEOUT_EN
                else if (cnt_q + 16'd1 == TIMEOUT_LIM) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready_o = (state_q == IDLE);
    assign bus.psel_o      = psel_q;
    assign bus.penable_o   = penable_q;
    assign bus.pwrite_o    = pwrite_q;
    assign bus.paddr_o     = paddr_q;
    assign bus.pwdata_o    = pwdata_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.rsp_err_o   = rsp_err_q;
endmodule

// File: tb/tb_apb_req_master.sv
// Directed bench for apb_req_master; inputs change and outputs are sampled 1ns after each rising edge.
module tb_apb_req_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    apb_req_master_if #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32)) bus ();

    apb_req_master #(
        .APB_ADDR_WIDTH(32),
        .APB_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Issue a request in the current cycle; returns after the SETUP edge with req_valid dropped.
    task automatic start_req(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = addr;
        bus.req_write_i = wr;
        bus.req_wdata_i = wdata;
        tick();
        bus.req_valid_i = 1'b0;
    endtask

    task automatic handshake();
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
    endtask

    initial begin
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_write_i = 1'b0;
        bus.req_wdata_i = '0;
        bus.rsp_ready_i = 1'b0;
        bus.prdata_i    = '0;
        bus.pready_i    = 1'b0;
        bus.pslverr_i   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // reset state
        check("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
        check("rst_psel",      64'(bus.psel_o),      64'd0);
        check("rst_penable",   64'(bus.penable_o),   64'd0);
        check("rst_pwrite",    64'(bus.pwrite_o),    64'd0);
        check("rst_paddr",     64'(bus.paddr_o),     64'd0);
        check("rst_pwdata",    64'(bus.pwdata_o),    64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        check("rst_rsp_rdata", 64'(bus.rsp_rdata_o), 64'd0);
        check("rst_rsp_err",   64'(bus.rsp_err_o),   64'd0);

        // read, zero wait; pready already high during SETUP must be ignored
        bus.pready_i = 1'b1;
        bus.prdata_i = 32'hCAFE_F00D;
        start_req(32'h1A10_0006, 1'b0, 32'h0);
        check("rd_setup_psel",    64'(bus.psel_o),      64'd1);
        check("rd_setup_penable", 64'(bus.penable_o),   64'd0);
        check("rd_setup_paddr",   64'(bus.paddr_o),     64'h1A10_0004);
        check("rd_setup_ready",   64'(bus.req_ready_o), 64'd0);
        check("rd_setup_rvalid",  64'(bus.rsp_valid_o), 64'd0);
        tick();
        check("rd_access_psel",    64'(bus.psel_o),      64'd1);
        check("rd_access_penable", 64'(bus.penable_o),   64'd1);
        check("rd_access_rvalid",  64'(bus.rsp_valid_o), 64'd0);
        tick();
        check("rd_resp_valid", 64'(bus.rsp_valid_o), 64'd1);
        check("rd_resp_rdata", 64'(bus.rsp_rdata_o), 64'hCAFE_F00D);
        check("rd_resp_err",   64'(bus.rsp_err_o),   64'd0);
        check("rd_resp_psel",  64'(bus.psel_o),      64'd0);
        check("rd_resp_pen",   64'(bus.penable_o),   64'd0);
        handshake();
        check("rd_done_valid", 64'(bus.rsp_valid_o), 64'd0);
        check("rd_done_ready", 64'(bus.req_ready_o), 64'd1);

        // write with 3 wait states
        bus.pready_i = 1'b0;
        bus.prdata_i = 32'hDEAD_BEEF;
        start_req(32'h1A10_1000, 1'b1, 32'h1234_5678);
        check("wr_setup_pwrite", 64'(bus.pwrite_o), 64'd1);
        check("wr_setup_pwdata", 64'(bus.pwdata_o), 64'h1234_5678);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("wr_access_penable", 64'(bus.penable_o), 64'd1);
            check("wr_access_pwdata",  64'(bus.pwdata_o),  64'h1234_5678);
            check("wr_access_paddr",   64'(bus.paddr_o),   64'h1A10_1000);
            if (i == 3) bus.pready_i = 1'b1;
            tick();
        end
        check("wr_resp_valid", 64'(bus.rsp_valid_o), 64'd1);
        check("wr_resp_rdata", 64'(bus.rsp_rdata_o), 64'd0);
        check("wr_resp_err",   64'(bus.rsp_err_o),   64'd0);
        check("wr_resp_pen",   64'(bus.penable_o),   64'd0);
        handshake();
        check("wr_hold_pwdata", 64'(bus.pwdata_o), 64'h1234_5678);
        check("wr_hold_pwrite", 64'(bus.pwrite_o), 64'd1);

        // slave error
        bus.pslverr_i = 1'b1;
        bus.prdata_i  = 32'hFFFF_FFFF;
        start_req(32'h0000_0010, 1'b0, 32'h0);
        tick();
        tick();
        check("err_resp_valid", 64'(bus.rsp_valid_o), 64'd1);
        check("err_resp_err",   64'(bus.rsp_err_o),   64'd1);
        check("err_resp_rdata", 64'(bus.rsp_rdata_o), 64'd0);
        handshake();
        bus.pslverr_i = 1'b0;

        // response backpressure with req_valid held high
        bus.prdata_i    = 32'h55AA_55AA;
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 32'h0000_0020;
        bus.req_write_i = 1'b0;
        tick();
        tick();
        tick();
        bus.prdata_i   = 32'h0;
        bus.req_addr_i = 32'h0000_0044;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(bus.rsp_valid_o), 64'd1);
            check("bp_rdata", 64'(bus.rsp_rdata_o), 64'h55AA_55AA);
            check("bp_ready", 64'(bus.req_ready_o), 64'd0);
            check("bp_psel",  64'(bus.psel_o),      64'd0);
            tick();
        end
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
        check("bp_hs_valid", 64'(bus.rsp_valid_o), 64'd0);
        check("bp_hs_psel",  64'(bus.psel_o),      64'd0);
        check("bp_hs_ready", 64'(bus.req_ready_o), 64'd1);
        tick();
        bus.req_valid_i = 1'b0;
        check("bp_2nd_psel",  64'(bus.psel_o),  64'd1);
        check("bp_2nd_paddr", 64'(bus.paddr_o), 64'h0000_0044);
        bus.prdata_i = 32'h0000_0BAD;
        tick();
        tick();
        check("bp_2nd_rdata", 64'(bus.rsp_rdata_o), 64'h0000_0BAD);
        handshake();

`ifdef APB_REQ_TIMEOUT_EN
        // watchdog: pready stuck low
        bus.pready_i = 1'b0;
        start_req(32'h0000_0080, 1'b0, 32'h0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check("to_access_penable", 64'(bus.penable_o), 64'd1);
            check("to_access_rvalid",  64'(bus.rsp_valid_o), 64'd0);
            tick();
        end
        check("to_psel",  64'(bus.psel_o),      64'd0);
        check("to_valid", 64'(bus.rsp_valid_o), 64'd1);
        check("to_err",   64'(bus.rsp_err_o),   64'd1);
        check("to_rdata", 64'(bus.rsp_rdata_o), 64'd0);
        handshake();
        bus.pready_i = 1'b1;
        bus.prdata_i = 32'h0BAD_F00D;
        start_req(32'h0000_0084, 1'b0, 32'h0);
        tick();
        tick();
        check("to_next_err",   64'(bus.rsp_err_o),   64'd0);
        check("to_next_rdata", 64'(bus.rsp_rdata_o), 64'h0BAD_F00D);
        handshake();
`endif

        // async reset in the middle of ACCESS
        bus.pready_i = 1'b0;
        start_req(32'h0000_0100, 1'b1, 32'hA5A5_A5A5);
        tick();
        check("ar_pre_penable", 64'(bus.penable_o), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_psel",      64'(bus.psel_o),      64'd0);
        check("ar_penable",   64'(bus.penable_o),   64'd0);
        check("ar_rvalid",    64'(bus.rsp_valid_o), 64'd0);
        check("ar_paddr",     64'(bus.paddr_o),     64'd0);
        tick();
        #2;
        rst = 1'b0;
        bus.pready_i = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("ar_no_rsp",  64'(bus.rsp_valid_o), 64'd0);
            check("ar_no_psel", 64'(bus.psel_o),      64'd0);
            check("ar_ready",   64'(bus.req_ready_o), 64'd1);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
